// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter slice.
//   - State encoding for the access sequencer (IDLE -> ACCESS -> ACK).
//   - Port index constants: port 0 is the CPU load/store stage,
//     port 1 is the secondary (debug/loader) master.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        ACK    = ST_ACK
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-input round-robin pick.
//   req0, req1  : pending requests from port 0 / port 1
//   lastGrant   : port granted most recently
//   valid       : at least one request is pending
//   winner      : index of the port to serve next
// A lone requester always wins; when both request, the port that was
// not granted last time wins, which makes back-to-back contention
// alternate strictly.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = ~lastGrant;
        end else if (req1) begin
            winner = PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: access sequencer and 2-port round-robin arbiter in front
// of the single-port data memory.
//   clk, rst              : clock, synchronous active-high reset
//   req/we/addr/wdata 0,1 : per-port request (level, held until ack)
//   ack0, ack1            : one-cycle completion pulse per port
//   rdata0, rdata1        : per-port registered read data, held until
//                           that port's next read
//   busy                  : sequencer is not idle
//   MemWrite, MemRead     : memory strobes, active only during ACCESS
//   Address, WriteData    : latched address / write data to memory
//   ReadData              : combinational read data from memory
// Each transaction takes three cycles: IDLE (arbitrate and latch),
// ACCESS (single memory cycle), ACK (acknowledge, requests ignored).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_DIR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0,
    input  logic                      req1,
    input  logic                      we0,
    input  logic                      we1,
    input  logic [DATA_DIR_WIDTH-1:0] addr0,
    input  logic [DATA_DIR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]     wdata0,
    input  logic [DATA_WIDTH-1:0]     wdata1,
    output logic                      ack0,
    output logic                      ack1,
    output logic [DATA_WIDTH-1:0]     rdata0,
    output logic [DATA_WIDTH-1:0]     rdata1,
    output logic                      busy,
    output logic                      MemWrite,
    output logic                      MemRead,
    output logic [DATA_DIR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0]     WriteData,
    input  logic [DATA_WIDTH-1:0]     ReadData
);

    state_t state;
    logic   sel;        // port owning the transaction in flight
    logic   weQ;        // direction of the transaction in flight
    logic   lastGrant;  // reset to port 1 so port 0 wins the first tie

    logic grantValid;
    logic grantWinner;

    rr_arb2 uArb (
        .req0      (req0),
        .req1      (req1),
        .lastGrant (lastGrant),
        .valid     (grantValid),
        .winner    (grantWinner)
    );

    // Strobes are decoded from the state so memory only sees activity in
    // ACCESS; Address/WriteData may hold stale values elsewhere.
    assign busy     = (state != IDLE);
    assign MemRead  = (state == ACCESS) && !weQ;
    assign MemWrite = (state == ACCESS) &&  weQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= PORT_CPU;
            weQ       <= 1'b0;
            lastGrant <= PORT_DBG;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            Address   <= '0;
            WriteData <= '0;
        end else begin
            // Acks are single-cycle pulses; only ACCESS raises one.
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        sel       <= grantWinner;
                        lastGrant <= grantWinner;
                        weQ       <= (grantWinner == PORT_DBG) ? we1    : we0;
                        Address   <= (grantWinner == PORT_DBG) ? addr1  : addr0;
                        WriteData <= (grantWinner == PORT_DBG) ? wdata1 : wdata0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Memory read data is valid now; capture it for the
                    // owning port only, leaving the other port's data held.
                    if (!weQ) begin
                        if (sel == PORT_DBG) begin
                            rdata1 <= ReadData;
                        end else begin
                            rdata0 <= ReadData;
                        end
                    end
                    if (sel == PORT_DBG) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                    state <= ACK;
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter.
// Requests are pushed into per-port queues when issued; a negedge monitor
// pops the owning queue on every ack and checks the memory access, read
// data, grant timing and round-robin order against a memory image model.
module tb_dmem_arbiter;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         issueEdge;  // first rising edge that samples the request
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, busy, MemWrite, MemRead;
    logic [7:0] rdata0, rdata1, Address, WriteData, ReadData;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int ackTotal   = 0;

    bit   monEn = 1'b0;
    txn_t q0[$];
    txn_t q1[$];
    bit   active[2];
    int   waitCnt[2];
    int   remaining[2];

    logic [7:0] tbMem[256];
    logic [7:0] refMem[256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.DATA_WIDTH(8), .DATA_DIR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .MemWrite(MemWrite), .MemRead(MemRead),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
    );

    // Data memory: combinational read, write on the edge ending ACCESS.
    initial for (int i = 0; i < 256; i++) tbMem[i] <= 8'(i + 126);
    always @(posedge clk) if (MemWrite) tbMem[Address] <= WriteData;
    assign ReadData = tbMem[Address];

    initial for (int i = 0; i < 256; i++) refMem[i] = 8'(i + 126);

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         sValid;
    int         sCyc;
    logic [7:0] sAddr, sWd;
    logic       sWe;
    int         lastGrantM;
    int         lastAckEdge;
    logic [7:0] held[2];

    always @(negedge clk) begin : monitor
        txn_t t;
        int   p, n, g, expG;
        bit   strobe, otherWaiting;
        if (!monEn) begin
            sValid      = 1'b0;
            lastGrantM  = 1;
            lastAckEdge = cyc - 1;
            held[0]     = 8'h00;
            held[1]     = 8'h00;
        end else begin
            strobe = MemRead | MemWrite;
            check("busy_vs_phase", int'(busy), int'(strobe | ack0 | ack1));
            check("strobe_exclusive", int'(MemRead & MemWrite), 0);
            check("ack_exclusive", int'(ack0 & ack1), 0);
            if (sValid && sCyc == cyc - 1)
                check("access_then_ack", int'(ack0 | ack1), 1);
            if (ack0 | ack1) begin
                p = ack1 ? 1 : 0;
                n = (p == 0) ? q0.size() : q1.size();
                check("ack_outstanding", int'(n > 0), 1);
                if (n > 0) begin
                    t = (p == 0) ? q0.pop_front() : q1.pop_front();
                    g = cyc - 1;
                    check("access_cycle", sValid ? sCyc : -1, g);
                    check("access_addr", int'(sAddr), int'(t.addr));
                    check("access_dir", int'(sWe), int'(t.we));
                    if (t.we) check("access_wdata", int'(sWd), int'(t.wdata));
                    expG = (t.issueEdge > lastAckEdge + 2) ? t.issueEdge : lastAckEdge + 2;
                    check("grant_latency", g, expG);
                    if (p == 0) otherWaiting = (q1.size() > 0) && (q1[0].issueEdge <= g);
                    else        otherWaiting = (q0.size() > 0) && (q0[0].issueEdge <= g);
                    if (otherWaiting) check("rr_order", p, (lastGrantM == 0) ? 1 : 0);
                    lastGrantM  = p;
                    lastAckEdge = cyc;
                    if (t.we) refMem[t.addr] = t.wdata;
                    else      held[p] = refMem[t.addr];
                    $display("txn port%0d %s addr=%02h data=%02h grant@%0d", p,
                             t.we ? "WR" : "RD", t.addr, t.we ? t.wdata : held[p], g);
                end
            end
            check("rdata0_value", int'(rdata0), int'(held[0]));
            check("rdata1_value", int'(rdata1), int'(held[1]));
            if (strobe) begin
                sValid = 1'b1;
                sCyc   = cyc;
                sAddr  = Address;
                sWe    = MemWrite;
                sWd    = WriteData;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic setReq(input int p, input logic v);
        if (p == 0) req0 = v; else req1 = v;
    endtask

    // Called just after a rising edge; the request is first sampled at the next one.
    task automatic startTxn(input int p, input logic w, input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        t.we = w; t.addr = a; t.wdata = d; t.issueEdge = cyc + 1;
        if (p == 0) begin
            q0.push_back(t); we0 = w; addr0 = a; wdata0 = d;
        end else begin
            q1.push_back(t); we1 = w; addr1 = a; wdata1 = d;
        end
        setReq(p, 1'b1);
        active[p]  = 1'b1;
        waitCnt[p] = 0;
    endtask

    // mode 0: no new requests, 1: random, 2: continuous reads
    task automatic step(input int mode);
        bit a[2];
        bit justDone;
        @(negedge clk);
        a[0] = ack0;
        a[1] = ack1;
        ackTotal += int'(a[0]) + int'(a[1]);
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            justDone = 1'b0;
            if (active[p]) begin
                if (a[p]) begin
                    active[p] = 1'b0;
                    justDone  = 1'b1;
                    setReq(p, 1'b0);
                end else begin
                    waitCnt[p]++;
                    if (waitCnt[p] > 30) begin
                        compared++;
                        mismatched++;
                        $display("FAIL ack_timeout port%0d: no ack after %0d cycles, required within 30", p, waitCnt[p]);
                        active[p] = 1'b0;
                        setReq(p, 1'b0);
                    end
                end
            end
            if (!active[p] && remaining[p] > 0) begin
                if (mode == 2 || (mode == 1 && $urandom_range(0, justDone ? 1 : 3) == 0)) begin
                    remaining[p]--;
                    startTxn(p, (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1)),
                             8'($urandom_range(0, 7)), 8'($urandom));
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (active[0] || active[1]); i++) step(0);
    endtask

    initial begin : stim
        int  ackBefore;
        bit  found;
        remaining[0] = 0;
        remaining[1] = 0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ack0", int'(ack0), 0);
        check("reset_ack1", int'(ack1), 0);
        check("reset_rdata0", int'(rdata0), 0);
        check("reset_rdata1", int'(rdata1), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_MemRead", int'(MemRead), 0);
        check("reset_MemWrite", int'(MemWrite), 0);
        check("reset_Address", int'(Address), 0);
        check("reset_WriteData", int'(WriteData), 0);
        @(posedge clk);
        #1 monEn = 1'b1;

        // Simultaneous first requests: port 0 must win the first tie
        startTxn(0, 1'b0, 8'h00, 8'h00);
        startTxn(1, 1'b0, 8'h01, 8'h00);
        drain();
        check("first_tie_rdata0", int'(rdata0), 126);
        check("first_tie_rdata1", int'(rdata1), 127);

        // Single write then read-back
        startTxn(0, 1'b1, 8'h02, 8'hA5);
        drain();
        startTxn(0, 1'b0, 8'h02, 8'h00);
        drain();
        check("readback_rdata0", int'(rdata0), 'hA5);

        // Continuous contention: 4 acks in the observed window, alternating
        remaining[0] = 100;
        remaining[1] = 100;
        ackBefore = ackTotal;
        repeat (13) step(2);
        check("contention_ack_count", ackTotal - ackBefore, 4);
        remaining[0] = 0;
        remaining[1] = 0;
        drain();

        // Read-data isolation
        startTxn(1, 1'b0, 8'h01, 8'h00);
        drain();
        check("isolation_rdata1_before", int'(rdata1), 'h7F);
        startTxn(0, 1'b1, 8'h01, 8'h11);
        drain();
        check("isolation_rdata1_after", int'(rdata1), 'h7F);

        // Reset during the ACCESS cycle of a port 1 read; req1 stays high
        startTxn(1, 1'b0, 8'h03, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (MemRead) found = 1'b1;
        end
        check("rst_test_access_seen", int'(found), 1);
        monEn = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_ack1", int'(ack1), 0);
        check("midrst_rdata1", int'(rdata1), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_MemRead", int'(MemRead), 0);
        check("midrst_Address", int'(Address), 0);
        @(posedge clk);
        #1 monEn = 1'b1;
        waitCnt[1] = 0;
        drain();
        check("midrst_reserved_rdata1", int'(rdata1), 129);

        // Randomized traffic
        remaining[0] = 40;
        remaining[1] = 40;
        for (int i = 0; i < 3000 && (remaining[0] > 0 || remaining[1] > 0 || active[0] || active[1]); i++)
            step(1);
        check("random_complete", remaining[0] + remaining[1] + int'(active[0]) + int'(active[1]), 0);

        // Idle stability
        ackBefore = ackTotal;
        repeat (10) step(0);
        check("idle_ack_count", ackTotal - ackBefore, 0);
        check("scoreboard_empty", q0.size() + q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
